// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - parametrised single-clock FIFO with occupancy, threshold and sticky error flags
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign wr_acc       = wr_en && !full;
  assign rd_acc       = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = mem[rd_ptr];
  assign rd_valid = !empty;
`else
  logic [WIDTH-1:0] data_q;
  logic             rd_valid_q;

  assign data_out = data_q;
  assign rd_valid = rd_valid_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      data_q     <= '0;
      rd_valid_q <= 1'b0;
`endif
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      rd_valid_q <= 1'b0;
`endif
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
`ifndef SYNC_FIFO_FWFT_EN
      rd_valid_q <= rd_acc;
      if (rd_acc) data_q <= mem[rd_ptr];
`endif
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed vector bench for sync_fifo_flags (DEPTH=5, AF=4, AE=1)
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       reset, flush, wr_en, rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;

  int checks = 0;
  int failures = 0;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, fl, wr, rd;
    logic [7:0] din;
    int         cnt;
    logic       rv;
    logic [7:0] dout;
    logic       chk_dout;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic v(input logic rst, input logic fl, input logic wr, input logic rd, input logic [7:0] din,
                   input int cnt, input logic rv, input logic [7:0] dout, input logic ovf, input logic unf);
    vec_t t;
    t.rst = rst; t.fl = fl; t.wr = wr; t.rd = rd; t.din = din;
    t.cnt = cnt; t.rv = rv; t.dout = dout; t.chk_dout = 1'b1; t.ovf = ovf; t.unf = unf;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rst, input logic fl, input logic wr, input logic rd, input logic [7:0] din);
    @(negedge clk);
    reset = rst; flush = fl; wr_en = wr; rd_en = rd; data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input int idx, input int cnt);
    chk("count", idx, 32'(count), 32'(cnt));
    chk("full", idx, 32'(full), 32'(cnt == 5));
    chk("empty", idx, 32'(empty), 32'(cnt == 0));
    chk("almost_full", idx, 32'(almost_full), 32'(cnt >= 4));
    chk("almost_empty", idx, 32'(almost_empty), 32'(cnt <= 1));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;

`ifndef SYNC_FIFO_FWFT_EN
    v(1,0,0,0,8'h00, 0,0,8'h00, 0,0);
    // Fill and drain
    v(0,0,1,0,8'h11, 1,0,8'h00, 0,0);
    v(0,0,1,0,8'h22, 2,0,8'h00, 0,0);
    v(0,0,1,0,8'h33, 3,0,8'h00, 0,0);
    v(0,0,1,0,8'h44, 4,0,8'h00, 0,0);
    v(0,0,1,0,8'h55, 5,0,8'h00, 0,0);
    v(0,0,0,1,8'h00, 4,1,8'h11, 0,0);
    v(0,0,0,1,8'h00, 3,1,8'h22, 0,0);
    v(0,0,0,1,8'h00, 2,1,8'h33, 0,0);
    v(0,0,0,1,8'h00, 1,1,8'h44, 0,0);
    v(0,0,0,1,8'h00, 0,1,8'h55, 0,0);
    v(0,0,0,0,8'h00, 0,0,8'h55, 0,0);
    // Wrap-around: pointers end at 3 before the A0..A4 burst
    v(0,0,1,0,8'h01, 1,0,8'h55, 0,0);
    v(0,0,1,0,8'h02, 2,0,8'h55, 0,0);
    v(0,0,1,0,8'h03, 3,0,8'h55, 0,0);
    v(0,0,0,1,8'h00, 2,1,8'h01, 0,0);
    v(0,0,0,1,8'h00, 1,1,8'h02, 0,0);
    v(0,0,0,1,8'h00, 0,1,8'h03, 0,0);
    for (int i = 0; i < 5; i++) v(0,0,1,0,8'hA0 + 8'(i), i+1,0,8'h03, 0,0);
    for (int i = 0; i < 5; i++) v(0,0,0,1,8'h00, 4-i,1,8'hA0 + 8'(i), 0,0);
    // Collisions at full, then at empty
    for (int i = 0; i < 5; i++) v(0,0,1,0,8'hB0 + 8'(i), i+1,0,8'hA4, 0,0);
    v(0,0,1,1,8'hFF, 4,1,8'hB0, 1,0);
    for (int i = 1; i < 5; i++) v(0,0,0,1,8'h00, 4-i,1,8'hB0 + 8'(i), 1,0);
    v(0,0,1,1,8'hC0, 1,0,8'hB4, 1,1);
    // Steady-state concurrency at count=2
    v(0,0,1,0,8'hC1, 2,0,8'hB4, 1,1);
    v(0,0,1,1,8'hD0, 2,1,8'hC0, 1,1);
    v(0,0,1,1,8'hD1, 2,1,8'hC1, 1,1);
    for (int i = 2; i < 10; i++) v(0,0,1,1,8'hD0 + 8'(i), 2,1,8'hD0 + 8'(i-2), 1,1);
    // Flush beats write; flush on empty with rd_en leaves underflow clear
    v(0,0,1,0,8'hE0, 3,0,8'hD7, 1,1);
    v(0,1,1,0,8'hEE, 0,0,8'hD7, 0,0);
    v(0,1,0,1,8'h00, 0,0,8'hD7, 0,0);
    v(0,0,1,0,8'hF0, 1,0,8'hD7, 0,0);
    v(0,0,0,1,8'h00, 0,1,8'hF0, 0,0);
    v(0,0,0,1,8'h00, 0,0,8'hF0, 0,1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check_flags(i, vecs[i].cnt);
      chk("rd_valid", i, 32'(rd_valid), 32'(vecs[i].rv));
      if (vecs[i].chk_dout) chk("data_out", i, 32'(data_out), 32'(vecs[i].dout));
      chk("overflow", i, 32'(overflow), 32'(vecs[i].ovf));
      chk("underflow", i, 32'(underflow), 32'(vecs[i].unf));
    end

    // Reset during an in-flight read, with flush/rd/wr also asserted
    drive(0,0,1,0,8'h12);
    drive(0,0,1,0,8'h34);
    drive(0,0,0,1,8'h00);
    chk("pre_reset_rd_valid", 900, 32'(rd_valid), 32'd1);
    chk("pre_reset_data", 900, 32'(data_out), 32'h12);
    chk("pre_reset_underflow", 900, 32'(underflow), 32'd1);
    drive(1,1,1,1,8'h56);
    check_flags(901, 0);
    chk("reset_rd_valid", 901, 32'(rd_valid), 32'd0);
    chk("reset_data", 901, 32'(data_out), 32'h00);
    chk("reset_overflow", 901, 32'(overflow), 32'd0);
    chk("reset_underflow", 901, 32'(underflow), 32'd0);
    drive(0,0,0,0,8'h00);
    chk("post_reset_count", 902, 32'(count), 32'd0);
`else
    drive(1,0,0,0,8'h00);
    check_flags(0, 0);
    chk("rd_valid", 0, 32'(rd_valid), 32'd0);
    drive(0,0,1,0,8'h3C);
    check_flags(1, 1);
    chk("rd_valid", 1, 32'(rd_valid), 32'd1);
    chk("data_out", 1, 32'(data_out), 32'h3C);
    drive(0,0,1,0,8'h4D);
    chk("data_out_head", 2, 32'(data_out), 32'h3C);
    drive(0,0,0,1,8'h00);
    chk("data_out_next", 3, 32'(data_out), 32'h4D);
    drive(0,0,0,1,8'h00);
    check_flags(4, 0);
    chk("rd_valid", 4, 32'(rd_valid), 32'd0);
    drive(0,0,0,1,8'h00);
    chk("underflow", 5, 32'(underflow), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
